uart_prog_loader: RTL and testbench

Synthesizable UART boot loader for the Ghazi user project. It receives a program image as little-endian bytes on a serial pin, assembles the bytes into `DATA_W`-bit words and writes them sequentially into instruction memory. When the end-marker word arrives it releases the core from reset. It is the on-chip, parametrised successor of the bench-side serial programmer, with runtime baud selection, configurable word width, framing/overflow detection and optional parity.

---
 rtl/uart_prog_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART boot loader: receives little-endian bytes, packs them into DATA_W-bit words,
// writes them to instruction memory and releases the core on END_WORD.
// Optional even parity bit per frame when UART_PROG_PARITY_EN is defined.
module uart_prog_loader #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 12,
    parameter logic [DATA_W-1:0] END_WORD = DATA_W'(32'h0000_0FFF)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    input  logic [15:0]       clks_per_bit_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              done_o,
    output logic              core_rst_no,
    output logic              frame_err_o,
    output logic              ovf_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PROG_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } rx_state_t;

    rx_state_t   state_q, state_d;
    logic        rx_meta, rx_sync, rx_prev;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        stop_wait_q, stop_wait_d;
    logic        frame_err_d;
    logic        byte_valid;
    logic        par_good;
    logic [15:0] half_m1, full_m1;

    logic [CNT_W-1:0]  byte_cnt;
    logic [DATA_W-1:0] word_buf, word_full;
    logic              exhausted;

    assign half_m1     = (div_q >> 1) - 16'd1;
    assign full_m1     = div_q - 16'd1;
    assign core_rst_no = done_o;

`ifdef UART_PROG_PARITY_EN
    logic par_ok_q, par_ok_d;
    assign par_good = par_ok_q;
`else
    assign par_good = 1'b1;
`endif

    // Synchroniser plus one extra flop for falling-edge detection; idles high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            stop_wait_q <= 1'b0;
            frame_err_o <= 1'b0;
`ifdef UART_PROG_PARITY_EN
            par_ok_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            stop_wait_q <= stop_wait_d;
            frame_err_o <= frame_err_d;
`ifdef UART_PROG_PARITY_EN
            par_ok_q    <= par_ok_d;
`endif
        end
    end

    // Samples land when the per-state counter reaches its target, i.e. mid-bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        stop_wait_d = stop_wait_q;
        frame_err_d = frame_err_o;
        byte_valid  = 1'b0;
`ifdef UART_PROG_PARITY_EN
        par_ok_d    = par_ok_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!done_o && rx_prev && !rx_sync) begin
                    state_d = S_START;
                    div_d   = clks_per_bit_i;
                end
            end
            S_START: begin
                if (cnt_q == half_m1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == full_m1) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PROG_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PROG_PARITY_EN
            S_PARITY: begin
                if (cnt_q == full_m1) begin
                    cnt_d    = '0;
                    par_ok_d = ((^shift_q) == rx_sync);
                    state_d  = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (stop_wait_q) begin
                    cnt_d = '0;
                    if (rx_sync) begin
                        stop_wait_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end else if (cnt_q == full_m1) begin
                    cnt_d = '0;
                    if (rx_sync) begin
                        state_d = S_IDLE;
                        if (par_good) begin
                            byte_valid = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        stop_wait_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        word_full = word_buf;
        for (int k = 0; k < BYTES; k++) begin
            if (byte_cnt == CNT_W'(k)) begin
                word_full[8*k +: 8] = shift_q;
            end
        end
    end

    // Address advances the cycle after a write and sticks at the top once used.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_o      <= 1'b0;
            addr_o    <= '0;
            wdata_o   <= '0;
            done_o    <= 1'b0;
            ovf_o     <= 1'b0;
            byte_cnt  <= '0;
            word_buf  <= '0;
            exhausted <= 1'b0;
        end else begin
            we_o <= 1'b0;
            if (we_o) begin
                if (addr_o == '1) begin
                    exhausted <= 1'b1;
                end else begin
                    addr_o <= addr_o + 1'b1;
                end
            end
            if (byte_valid && !done_o) begin
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt <= '0;
                    if (word_full == END_WORD) begin
                        done_o <= 1'b1;
                    end else if (exhausted) begin
                        ovf_o <= 1'b1;
                    end else begin
                        we_o    <= 1'b1;
                        wdata_o <= word_full;
                    end
                end else begin
                    word_buf <= word_full;
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader (DATA_W=32, ADDR_W=2); parity steps
// are included when UART_PROG_PARITY_EN is defined.
module tb_uart_prog_loader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx    = 1'b1;
    logic [15:0]       div   = 16'd8;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              done;
    logic              core_rst_n;
    logic              frame_err;
    logic              ovf;

    int tests    = 0;
    int failures = 0;

    logic [ADDR_W-1:0] wr_addr [64];
    logic [DATA_W-1:0] wr_data [64];
    int                wr_cnt = 0;
    int                base;

`ifdef UART_PROG_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_prog_loader #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .END_WORD (32'h0000_0FFF)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .rx_i           (rx),
        .clks_per_bit_i (div),
        .we_o           (we),
        .addr_o         (addr),
        .wdata_o        (wdata),
        .done_o         (done),
        .core_rst_no    (core_rst_n),
        .frame_err_o    (frame_err),
        .ovf_o          (ovf)
    );

    always #5 clk = ~clk;

    // Log every write strobe so data and addresses can be compared later.
    always @(negedge clk) begin
        if (we) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = addr;
                wr_data[wr_cnt] = wdata;
            end
            wr_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bitPeriod(input logic v);
        rx = v;
        repeat (int'(div)) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stop_bit);
        bitPeriod(1'b0);
        for (int i = 0; i < 8; i++) bitPeriod(b[i]);
`ifdef UART_PROG_PARITY_EN
        bitPeriod((^b) ^ par_flip);
`endif
        bitPeriod(stop_bit);
    endtask

    task automatic applyStimulus(input logic [31:0] w);
        for (int k = 0; k < 4; k++) sendFrame(w[8*k +: 8], 1'b1);
    endtask

    task automatic doReset();
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_we", 64'(we), 64'd0);
        checkOutput("rst_addr", 64'(addr), 64'd0);
        checkOutput("rst_wdata", 64'(wdata), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_core_rst_n", 64'(core_rst_n), 64'd0);
        checkOutput("rst_frame_err", 64'(frame_err), 64'd0);
        checkOutput("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        idle(4);

        // Short glitch while idle must not start a frame
        div = 16'd16;
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(60);
        checkOutput("glitch_writes", 64'(wr_cnt), 64'd0);
        checkOutput("glitch_frame_err", 64'(frame_err), 64'd0);
        checkOutput("glitch_done", 64'(done), 64'd0);

        // Two words then END_WORD
        div = 16'd8;
        applyStimulus(32'h1234_5678);
        applyStimulus(32'hDEAD_BEEF);
        applyStimulus(32'h0000_0FFF);
        idle(8);
        checkOutput("img_writes", 64'(wr_cnt), 64'd2);
        checkOutput("img_addr0", 64'(wr_addr[0]), 64'd0);
        checkOutput("img_data0", 64'(wr_data[0]), 64'h1234_5678);
        checkOutput("img_addr1", 64'(wr_addr[1]), 64'd1);
        checkOutput("img_data1", 64'(wr_data[1]), 64'hDEAD_BEEF);
        checkOutput("img_done", 64'(done), 64'd1);
        checkOutput("img_core_rst_n", 64'(core_rst_n), 64'd1);
        checkOutput("img_frame_err", 64'(frame_err), 64'd0);
        checkOutput("img_addr_next", 64'(addr), 64'd2);
        applyStimulus(32'h0A0B_0C0D);
        idle(8);
        checkOutput("post_done_writes", 64'(wr_cnt), 64'd2);

        // Bad stop bit, then a clean word
        doReset();
        base = wr_cnt;
        sendFrame(8'h55, 1'b0);
        idle(24);
        checkOutput("ferr_flag", 64'(frame_err), 64'd1);
        checkOutput("ferr_no_write", 64'(wr_cnt - base), 64'd0);
        applyStimulus(32'hDDCC_BBAA);
        idle(8);
        checkOutput("ferr_writes", 64'(wr_cnt - base), 64'd1);
        checkOutput("ferr_data", 64'(wr_data[base]), 64'hDDCC_BBAA);
        checkOutput("ferr_addr", 64'(wr_addr[base]), 64'd0);

        // Address exhaustion with ADDR_W=2
        doReset();
        base = wr_cnt;
        for (int i = 1; i <= 5; i++) applyStimulus(32'h0101_0101 * i);
        idle(8);
        checkOutput("ovf_writes", 64'(wr_cnt - base), 64'd4);
        checkOutput("ovf_last_addr", 64'(wr_addr[base + 3]), 64'd3);
        checkOutput("ovf_last_data", 64'(wr_data[base + 3]), 64'h0404_0404);
        checkOutput("ovf_flag", 64'(ovf), 64'd1);
        checkOutput("ovf_addr_hold", 64'(addr), 64'd3);
        checkOutput("ovf_done_before", 64'(done), 64'd0);
        applyStimulus(32'h0000_0FFF);
        idle(8);
        checkOutput("ovf_end_done", 64'(done), 64'd1);

        // Reset during DATA bit 4 of the second byte of a word
        doReset();
        base = wr_cnt;
        applyStimulus(32'h1122_3344);
        sendFrame(8'hAB, 1'b1);
        idle(4);
        checkOutput("mid_pre_addr", 64'(addr), 64'd1);
        checkOutput("mid_pre_wdata", 64'(wdata), 64'h1122_3344);
        bitPeriod(1'b0);
        for (int i = 0; i < 4; i++) bitPeriod(1'(8'hCD >> i));
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_we", 64'(we), 64'd0);
        checkOutput("mid_addr", 64'(addr), 64'd0);
        checkOutput("mid_wdata", 64'(wdata), 64'd0);
        checkOutput("mid_done", 64'(done), 64'd0);
        checkOutput("mid_ovf", 64'(ovf), 64'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        base = wr_cnt;
        applyStimulus(32'hCAFE_F00D);
        applyStimulus(32'h0000_0FFF);
        idle(8);
        checkOutput("fresh_writes", 64'(wr_cnt - base), 64'd1);
        checkOutput("fresh_addr", 64'(wr_addr[base]), 64'd0);
        checkOutput("fresh_data", 64'(wr_data[base]), 64'hCAFE_F00D);
        checkOutput("fresh_done", 64'(done), 64'd1);

`ifdef UART_PROG_PARITY_EN
        // 0x07 with parity 0 is rejected; with parity 1 it is accepted
        doReset();
        base = wr_cnt;
        par_flip = 1'b1;
        sendFrame(8'h07, 1'b1);
        par_flip = 1'b0;
        idle(8);
        checkOutput("par_bad_flag", 64'(frame_err), 64'd1);
        applyStimulus(32'h0000_0007);
        idle(8);
        checkOutput("par_writes", 64'(wr_cnt - base), 64'd1);
        checkOutput("par_data", 64'(wr_data[base]), 64'h0000_0007);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
